// File: rtl/spi_regbank_peripheral.sv
// -----------------------------------------------------------------------------
// spi_regbank_peripheral
//
// SPI mode-0 register bank. A frame is R/W (1 = write), ADDR_W address bits
// MSB first, then DATA_W data bits MSB first. Write frames commit into one of
// NUM_REGS registers when chip select rises. Read frames return the addressed
// register on sdo during the data phase. All SPI pins are synchronised into the
// clk domain, so clk must run at least 8x sclk.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (released synchronously upstream)
//   sclk       SPI serial clock, idles low
//   ncs        SPI chip select, active low
//   sdi        controller-out serial data
//   sdo        peripheral-out serial data, 0 whenever sdo_oe is low
//   sdo_oe     high while the read data phase is being driven
//   regs_out   flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-clk pulse on the commit of reg i
//   frame_err  one-clk pulse when a malformed frame ends
// -----------------------------------------------------------------------------
module spi_regbank_peripheral #(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk,
   input  logic                         ncs,
   input  logic                         sdi,
   output logic                         sdo,
   output logic                         sdo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic                         frame_err
);

   localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
   // Count value just before the edge that completes the R/W + address header.
   localparam logic [CNT_W-1:0] CNT_PRE_HDR = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_HDR     = CNT_W'(ADDR_W + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, sdi_sync_q;
   logic                   sclk_prev_q, ncs_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         ncs_sync_q  <= '1;
         sdi_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         ncs_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
      end
   end

   logic sclk_s, ncs_s, sdi_s;
   logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, bit_edge;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ncs_rise  = ncs_s & ~ncs_prev_q;
   assign ncs_fall  = ~ncs_s & ncs_prev_q;
   assign bit_edge  = sclk_rise & ~ncs_s;

   // ------------------------------------------------------ receive path
   logic [FRAME_LEN-1:0] rx_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 overrun_q;
   logic [FRAME_LEN-1:0] shift_next;
   logic                 hdr_done;
   logic                 hdr_rw;
   logic [ADDR_W-1:0]    hdr_addr;

   // The header decode looks at the shift value including the bit arriving
   // on this edge, so the read register can be loaded in the same cycle.
   assign shift_next = {rx_q[FRAME_LEN-2:0], sdi_s};
   assign hdr_done   = bit_edge && (cnt_q == CNT_PRE_HDR);
   assign hdr_rw     = shift_next[ADDR_W];
   assign hdr_addr   = shift_next[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q      <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else if (ncs_rise) begin
         rx_q      <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else if (bit_edge) begin
         if (cnt_q == CNT_FULL) begin
            overrun_q <= 1'b1;             // extra edge: frame kept intact
         end else begin
            rx_q  <= shift_next;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t state_q, state_d;
   logic   read_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      read_load = 1'b0;
      case (state_q)
         ST_IDLE:  if (ncs_fall) state_d = ST_ADDR;
         ST_ADDR: begin
            if (hdr_done) begin
               if (hdr_rw) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d   = ST_RDATA;
                  read_load = 1'b1;
               end
            end
         end
         ST_WDATA, ST_RDATA: begin
            if (bit_edge && (cnt_q == CNT_LAST)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
      if (ncs_rise) state_d = ST_IDLE;
   end

   // ------------------------------------------------ commit / error path
   // Address and data are copied into holding registers at the ncs rise so a
   // new frame starting right away cannot disturb the pending commit.
   logic              commit_vld_q;
   logic [ADDR_W-1:0] commit_addr_q;
   logic [DATA_W-1:0] commit_data_q;
   logic              frame_err_q;
   logic              commit_ok;
   logic              frame_bad;

   assign commit_ok = ncs_rise && (cnt_q == CNT_FULL) && rx_q[FRAME_LEN-1] && !overrun_q;
   assign frame_bad = ncs_rise && (((cnt_q != '0) && (cnt_q != CNT_FULL)) || overrun_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_vld_q  <= 1'b0;
         commit_addr_q <= '0;
         commit_data_q <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         commit_vld_q <= commit_ok;
         frame_err_q  <= frame_bad;
         if (commit_ok) begin
            commit_addr_q <= rx_q[DATA_W +: ADDR_W];
            commit_data_q <= rx_q[DATA_W-1:0];
         end
      end
   end

   assign frame_err = frame_err_q;

   // ------------------------------------------------------ register bank
   // Addresses beyond NUM_REGS match no slot and are silently dropped.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic              strobe_q;
      logic              hit;

      assign hit = commit_vld_q && (commit_addr_q == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            reg_q    <= '0;
            strobe_q <= 1'b0;
         end else begin
            strobe_q <= hit;
            if (hit) reg_q <= commit_data_q;
         end
      end

      assign regs_out[gi*DATA_W +: DATA_W] = reg_q;
      assign wr_strobe[gi]                 = strobe_q;
   end

   // ------------------------------------------------------- transmit path
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] tx_q;
   logic              oe_q;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (hdr_addr == ADDR_W'(i)) rd_val = regs_out[i*DATA_W +: DATA_W];
      end
   end

   // The MSB is held across the falling edge that follows the header so it
   // is still valid at the first data rising edge; shifting starts after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q <= '0;
         oe_q <= 1'b0;
      end else if (ncs_rise) begin
         tx_q <= '0;
         oe_q <= 1'b0;
      end else if (read_load) begin
         tx_q <= rd_val;
         oe_q <= 1'b1;
      end else if (sclk_fall && oe_q) begin
         if (cnt_q == CNT_FULL) begin
            oe_q <= 1'b0;
         end else if (cnt_q > CNT_HDR) begin
            tx_q <= tx_q << 1;
         end
      end
   end

   assign sdo    = oe_q & tx_q[DATA_W-1];
   assign sdo_oe = oe_q;

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Bench for spi_regbank_peripheral: directed scenarios plus random frames,
// checked against an array model of the register bank.
module tb_spi_regbank_peripheral;

   localparam int NUM_REGS = 5;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 7;
   localparam int SYNC     = 2;
   localparam int FL       = 1 + ADDR_W + DATA_W;

   logic                       clk = 1'b0;
   logic                       rst_n, sclk, ncs, sdi;
   logic                       sdo, sdo_oe, frame_err;
   logic [NUM_REGS*DATA_W-1:0] regs_out;
   logic [NUM_REGS-1:0]        wr_strobe;

   spi_regbank_peripheral #(
      .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .sdi(sdi),
      .sdo(sdo), .sdo_oe(sdo_oe), .regs_out(regs_out),
      .wr_strobe(wr_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------- monitors
   int                  cyc = 0;
   int                  strobe_cnt [NUM_REGS];
   int                  strobe_cyc [NUM_REGS];
   int                  long_strobe = 0;
   int                  err_cnt = 0;
   int                  long_err = 0;
   int                  sdo_bad = 0;
   logic [NUM_REGS-1:0] strobe_prev = '0;
   logic                err_prev = 1'b0;
   int                  raise_cyc = 0;

   initial for (int i = 0; i < NUM_REGS; i++) begin
      strobe_cnt[i] = 0;
      strobe_cyc[i] = 0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_strobe[i] && !strobe_prev[i]) begin
               strobe_cnt[i] <= strobe_cnt[i] + 1;
               strobe_cyc[i] <= cyc;
            end
            if (wr_strobe[i] && strobe_prev[i]) long_strobe <= long_strobe + 1;
         end
         if (frame_err && !err_prev) err_cnt <= err_cnt + 1;
         if (frame_err && err_prev) long_err <= long_err + 1;
         if (!sdo_oe && sdo !== 1'b0) sdo_bad <= sdo_bad + 1;
      end
      strobe_prev <= wr_strobe;
      err_prev    <= frame_err;
   end

   // -------------------------------------------------------------- model
   logic [DATA_W-1:0] model [NUM_REGS];

   function automatic logic [NUM_REGS*DATA_W-1:0] model_vec();
      logic [NUM_REGS*DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
      return v;
   endfunction

   // ---------------------------------------------------------- helpers
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clocks nbits out MSB first; returns the sdo bits seen before the data
   // rising edges and whether sdo_oe matched the expected phase throughout.
   task automatic send_bits(input int nbits, input logic [31:0] word, input bit is_read,
                            output logic [7:0] rd, output bit oe_ok);
      bit exp_oe;
      rd    = '0;
      oe_ok = 1'b1;
      for (int k = 0; k < nbits; k++) begin
         sdi = word[nbits-1-k];
         wait_clk(8);
         exp_oe = is_read && (k >= 1 + ADDR_W) && (k < FL);
         if (exp_oe) rd = {rd[6:0], sdo};
         if (sdo_oe !== exp_oe) oe_ok = 1'b0;
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input int nbits, input logic [31:0] word, input bit is_read,
                             output logic [7:0] rd, output bit oe_ok, output logic oe_after);
      ncs = 1'b0;
      wait_clk(4);
      send_bits(nbits, word, is_read, rd, oe_ok);
      wait_clk(8);
      oe_after = sdo_oe;
      @(posedge clk);
      #1;
      ncs       = 1'b1;
      raise_cyc = cyc;
   endtask

   task automatic run_check(input string name, input int nbits, input logic [31:0] word);
      logic [15:0]       frm;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data, rd, exp_rd;
      bit                oe_ok, is_read, exp_commit, exp_err;
      logic              oe_after;
      int                s0 [NUM_REGS];
      int                e0;
      logic [63:0]       got_v, exp_v;

      frm        = (nbits >= FL) ? 16'(word >> (nbits - FL)) : 16'h0;
      rw         = frm[15];
      addr       = frm[14:8];
      data       = frm[7:0];
      is_read    = (nbits == FL) && !rw;
      exp_commit = (nbits == FL) && rw && (int'(addr) < NUM_REGS);
      exp_err    = (nbits != 0) && (nbits != FL);
      exp_rd     = (int'(addr) < NUM_REGS) ? model[addr] : '0;
      for (int i = 0; i < NUM_REGS; i++) s0[i] = strobe_cnt[i];
      e0 = err_cnt;

      send_frame(nbits, word, is_read, rd, oe_ok, oe_after);
      wait_clk(16);

      if (exp_commit) model[addr] = data;
      got_v = '0;
      exp_v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         got_v[i*4 +: 4] = 4'(strobe_cnt[i] - s0[i]);
         exp_v[i*4 +: 4] = (exp_commit && int'(addr) == i) ? 4'd1 : 4'd0;
      end
      chk({name, " strobes"}, got_v, exp_v);
      chk({name, " frame_err"}, 64'(err_cnt - e0), 64'(exp_err));
      chk({name, " regs_out"}, 64'(regs_out), 64'(model_vec()));
      chk({name, " oe phase"}, 64'(oe_ok), 64'd1);
      chk({name, " oe idle"}, 64'(sdo_oe), 64'd0);
      if (exp_commit)
         chk({name, " latency"}, 64'(strobe_cyc[addr] - raise_cyc), 64'(SYNC + 2));
      if (is_read) begin
         chk({name, " read data"}, 64'(rd), 64'(exp_rd));
         chk({name, " oe after last"}, 64'(oe_after), 64'd0);
      end
      $display("txn %s: bits=%0d rw=%0b addr=%0h data=%0h rd=%0h regs=%0h",
               name, nbits, rw, addr, data, rd, regs_out);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [7:0]  rd;
      bit          oe_ok;
      logic        oe_after;
      int          s2, s3, e0;
      logic [31:0] w;

      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; sdi = 1'b0;
      wait_clk(3);
      chk("reset regs_out", 64'(regs_out), 64'd0);
      chk("reset wr_strobe", 64'(wr_strobe), 64'd0);
      chk("reset frame_err", 64'(frame_err), 64'd0);
      chk("reset sdo", 64'(sdo), 64'd0);
      chk("reset sdo_oe", 64'(sdo_oe), 64'd0);
      rst_n = 1'b1;
      wait_clk(4);

      run_check("wr_r1_a5", FL, 32'h81A5);
      run_check("wr_r4_80", FL, 32'h8480);
      run_check("rd_r4", FL, 32'h0400);
      run_check("wr_7f_ff", FL, 32'hFFFF);
      run_check("rd_7f", FL, 32'h7F00);
      run_check("short10", 10, 32'h81A5 >> 6);
      run_check("overrun17", 17, {15'h0, 16'h803C, 1'b1});

      // back-to-back writes with the shortest ncs-high gap the synchroniser sees
      s2 = strobe_cnt[2]; s3 = strobe_cnt[3]; e0 = err_cnt;
      send_frame(FL, 32'h8211, 1'b0, rd, oe_ok, oe_after);
      wait_clk(SYNC + 1);
      send_frame(FL, 32'h8322, 1'b0, rd, oe_ok, oe_after);
      wait_clk(16);
      model[2] = 8'h11;
      model[3] = 8'h22;
      chk("b2b strobe r2", 64'(strobe_cnt[2] - s2), 64'd1);
      chk("b2b strobe r3", 64'(strobe_cnt[3] - s3), 64'd1);
      chk("b2b frame_err", 64'(err_cnt - e0), 64'd0);
      chk("b2b regs_out", 64'(regs_out), 64'(model_vec()));
      $display("txn b2b: r2=11 r3=22 regs=%0h", regs_out);

      // reset after 9 bits of a write frame
      e0 = err_cnt;
      ncs = 1'b0;
      wait_clk(4);
      send_bits(9, 32'h101, 1'b0, rd, oe_ok);
      rst_n = 1'b0;
      wait_clk(2);
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      chk("midrst regs_out", 64'(regs_out), 64'd0);
      chk("midrst strobe", 64'(wr_strobe), 64'd0);
      chk("midrst sdo_oe", 64'({sdo_oe, sdo, frame_err}), 64'd0);
      ncs = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(8);
      chk("midrst no err", 64'(err_cnt - e0), 64'd0);
      $display("txn midrst: regs=%0h", regs_out);
      run_check("wr_r0_5a", FL, 32'h805A);

      for (int n = 0; n < 12; n++) begin
         w = (32'($urandom_range(0, 1)) << 15) | (32'($urandom_range(0, 7)) << 8)
             | (32'($urandom) & 32'hFF);
         run_check($sformatf("rand%0d", n), FL, w);
      end

      chk("strobe width", 64'(long_strobe), 64'd0);
      chk("frame_err width", 64'(long_err), 64'd0);
      chk("sdo idle zero", 64'(sdo_bad), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
